// File: rtl/riscv_hwlp_pkg.sv
// Shared encodings for the RI5CY hardware-loop scheduler: readback selects,
// write-enable bit positions and scheduler states.
package riscv_hwlp_pkg;

    localparam logic [1:0] HWLP_SEL_START = 2'd0;
    localparam logic [1:0] HWLP_SEL_END   = 2'd1;
    localparam logic [1:0] HWLP_SEL_CNT   = 2'd2;
    localparam logic [1:0] HWLP_SEL_STATS = 2'd3;

    localparam int HWLP_WE_START = 0;
    localparam int HWLP_WE_END   = 1;
    localparam int HWLP_WE_CNT   = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        DEC_PEND = 1'b1
    } hwlp_state_e;

endpackage

// File: rtl/riscv_hwlp_match.sv
// End-of-loop match for one register set. A count of 2 whose decrement is
// already pending is effectively 1, so it must not trigger another jump.
module riscv_hwlp_match
    import riscv_hwlp_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic [31:0]      pc_i,
    input  logic [31:0]      end_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             pend_hit_i,
    output logic             match_o
);

    logic cnt_ge3;
    logic cnt_eq2;

    assign cnt_ge3 = cnt_i >= CNT_W'(3);
    assign cnt_eq2 = cnt_i == CNT_W'(2);
    assign match_o = (pc_i == end_i) && (cnt_ge3 || (cnt_eq2 && !pend_hit_i));

endmodule

// File: rtl/riscv_hwlp_sched.sv
// Hardware-loop register bank and jump scheduler for the RI5CY ID stage.
// Optional per-set jump statistics are enabled by defining RISCV_HWLP_STATS_EN.
//
// state    | meaning
// IDLE     | no counter decrement outstanding
// DEC_PEND | cnt[pend_id] decrements at the end of this cycle unless killed
module riscv_hwlp_sched
    import riscv_hwlp_pkg::*;
#(
    parameter int N_REGSETS = 2,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  current_pc_i,
    input  logic                         id_accept_i,
    input  logic                         kill_i,
    input  logic [2:0]                   hwlp_we_i,
    input  logic [$clog2(N_REGSETS)-1:0] hwlp_regid_i,
    input  logic [31:0]                  hwlp_wdata_i,
    input  logic [$clog2(N_REGSETS)-1:0] hwlp_raddr_i,
    input  logic [1:0]                   hwlp_rsel_i,
    output logic [31:0]                  hwlp_rdata_o,
    output logic                         hwlp_jump_o,
    output logic [31:0]                  hwlp_targ_addr_o,
    output logic [N_REGSETS-1:0]         hwlp_active_o
);

    localparam int RID_W = $clog2(N_REGSETS);

    logic [31:0]      start_q [N_REGSETS];
    logic [31:0]      start_d [N_REGSETS];
    logic [31:0]      end_q   [N_REGSETS];
    logic [31:0]      end_d   [N_REGSETS];
    logic [CNT_W-1:0] cnt_q   [N_REGSETS];
    logic [CNT_W-1:0] cnt_d   [N_REGSETS];

    hwlp_state_e      state_q, state_d;
    logic [RID_W-1:0] pend_id_q, pend_id_d;

    logic [N_REGSETS-1:0] match;
    logic [RID_W-1:0]     winner;
    logic                 take;
    logic                 dec_en;
    logic                 wr_ok;
    logic                 rd_ok;

    for (genvar g = 0; g < N_REGSETS; g++) begin : g_set
        riscv_hwlp_match #(.CNT_W(CNT_W)) u_match (
            .pc_i       (current_pc_i),
            .end_i      (end_q[g]),
            .cnt_i      (cnt_q[g]),
            .pend_hit_i ((state_q == DEC_PEND) && (pend_id_q == RID_W'(g))),
            .match_o    (match[g])
        );
        assign hwlp_active_o[g] = cnt_q[g] != '0;
    end

    // Out-of-range set ids only exist when N_REGSETS is not a power of two.
    if ((2 ** RID_W) == N_REGSETS) begin : g_full_idx
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_part_idx
        assign wr_ok = 32'(hwlp_regid_i) < 32'(N_REGSETS);
        assign rd_ok = 32'(hwlp_raddr_i) < 32'(N_REGSETS);
    end

    always_comb begin
        winner = '0;
        for (int i = N_REGSETS - 1; i >= 0; i--) begin
            if (match[i]) winner = RID_W'(i);
        end
    end

    assign hwlp_jump_o      = |match;
    assign hwlp_targ_addr_o = hwlp_jump_o ? start_q[winner] : 32'd0;
    assign take             = hwlp_jump_o & id_accept_i & ~kill_i;
    assign dec_en           = (state_q == DEC_PEND) & ~kill_i;

    always_comb begin
        state_d   = state_q;
        pend_id_d = pend_id_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d   = DEC_PEND;
                    pend_id_d = winner;
                end
            end
            DEC_PEND: begin
                if (take) pend_id_d = winner;
                else      state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes are applied after the decrement so a same-cycle counter write wins.
    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        if (dec_en && (cnt_q[pend_id_q] != '0)) begin
            cnt_d[pend_id_q] = cnt_q[pend_id_q] - CNT_W'(1);
        end
        if (wr_ok) begin
            if (hwlp_we_i[HWLP_WE_START]) start_d[hwlp_regid_i] = hwlp_wdata_i;
            if (hwlp_we_i[HWLP_WE_END])   end_d[hwlp_regid_i]   = hwlp_wdata_i;
            if (hwlp_we_i[HWLP_WE_CNT])   cnt_d[hwlp_regid_i]   = hwlp_wdata_i[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGSETS; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            state_q   <= IDLE;
            pend_id_q <= '0;
        end else begin
            start_q   <= start_d;
            end_q     <= end_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            pend_id_q <= pend_id_d;
        end
    end

`ifdef RISCV_HWLP_STATS_EN
    logic [15:0] stats_q [N_REGSETS];
    logic [15:0] stats_d [N_REGSETS];

    always_comb begin
        stats_d = stats_q;
        if (take) stats_d[winner] = stats_q[winner] + 16'd1;
        if (wr_ok && hwlp_we_i[HWLP_WE_CNT]) stats_d[hwlp_regid_i] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGSETS; i++) stats_q[i] <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end
`endif

    always_comb begin
        hwlp_rdata_o = '0;
        if (rd_ok) begin
            case (hwlp_rsel_i)
                HWLP_SEL_START: hwlp_rdata_o = start_q[hwlp_raddr_i];
                HWLP_SEL_END:   hwlp_rdata_o = end_q[hwlp_raddr_i];
                HWLP_SEL_CNT:   hwlp_rdata_o = 32'(cnt_q[hwlp_raddr_i]);
`ifdef RISCV_HWLP_STATS_EN
                HWLP_SEL_STATS: hwlp_rdata_o = 32'(stats_q[hwlp_raddr_i]);
`else
                HWLP_SEL_STATS: hwlp_rdata_o = '0;
`endif
            endcase
        end
    end

endmodule

// File: doc/riscv_hwlp_sched.md
Name: riscv_hwlp_sched

Overview:
Hardware-loop register bank and scheduler for the RI5CY ID stage.
- Holds N_REGSETS loop sets (start, end, counter) and accepts setup writes from the ID/CSR path.
- Compares the current PC against every end address and arbitrates between matching sets, with the inner loop having priority.
- Issues the jump target to ID and sequences the counter decrement through a one-deep pending stage. This stage replaces the external in-flight decrement signal.

Parameters:
N_REGSETS, 2, number of loop register sets; set 0 is the innermost loop (highest priority).
CNT_W, 32, loop counter width; must be >= 3.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
current_pc_i  in  32  PC of the instruction currently in ID
id_accept_i  in  1  instruction in ID advances this cycle
kill_i  in  1  flush; cancels a pending decrement
hwlp_we_i  in  3  write enables: [0] start, [1] end, [2] counter
hwlp_regid_i  in  $clog2(N_REGSETS)  target set for a write
hwlp_wdata_i  in  32  write data; the counter takes the low CNT_W bits
hwlp_raddr_i  in  $clog2(N_REGSETS)  readback set
hwlp_rsel_i  in  2  readback select: 0 start, 1 end, 2 counter, 3 stats
hwlp_rdata_o  out  32  combinational readback
hwlp_jump_o  out  1  jump to loop start
hwlp_targ_addr_o  out  32  jump target
hwlp_active_o  out  N_REGSETS  set i has counter != 0

Behaviour:
- Reset (synchronous, rst=1):
  - All start, end and counter registers cleared to 0.
  - FSM goes to IDLE.
  - Outputs: hwlp_jump_o=0, hwlp_targ_addr_o=0, hwlp_active_o=0, hwlp_rdata_o reflects cleared registers.
  - Reset asserted mid-operation drops any pending decrement.
- Match for set i: current_pc_i==end[i] AND one of:
  - cnt[i]>=3, or
  - cnt[i]==2 AND NOT (state==DEC_PEND AND pend_id==i).
  - cnt 1 and 0 never match.
- Arbitration: the lowest-index matching set wins.
  - hwlp_jump_o = any match; hwlp_targ_addr_o = start[winner]. Both are combinational, zero latency.
  - With no match, hwlp_targ_addr_o = 0 (never X).
- FSM states:
  - IDLE: if hwlp_jump_o & id_accept_i & ~kill_i, latch pend_id=winner and go to DEC_PEND.
  - DEC_PEND: next clock, cnt[pend_id] -= 1, saturating at 0. If a new accepted jump occurs in the same cycle, stay in DEC_PEND with the new pend_id; otherwise go to IDLE.
  - kill_i in DEC_PEND discards the decrement and returns to IDLE.
- Writes take effect at the clock edge; multiple hwlp_we_i bits may be set together.
- Simultaneous write and decrement:
  - A counter write to pend_id wins; the decrement is dropped.
  - A start/end write to pend_id does not affect the decrement.
- Writes to hwlp_regid_i >= N_REGSETS are ignored.
- Reads of hwlp_raddr_i >= N_REGSETS return 0.
- Counter readback is zero-extended to 32 bits.
- A counter written to 0 deactivates the set immediately (next cycle).

Optional Feature:
RISCV_HWLP_STATS_EN:
- Defined: each set has a 16-bit counter of taken-and-accepted jumps.
  - Increments in the same cycle as the IDLE->DEC_PEND or DEC_PEND->DEC_PEND transition.
  - Wraps 0xFFFF->0; cleared by reset or by any counter write to that set.
  - Read via rsel=3, zero-extended.
- Undefined: no stats registers; rsel=3 reads 0.

Decomposition:
- Package riscv_hwlp_pkg:
  - rsel encodings (HWLP_SEL_START/END/CNT/STATS);
  - hwlp_we bit indices;
  - FSM state enum {IDLE, DEC_PEND}.
- Sub-module riscv_hwlp_match: one per set, generated N_REGSETS times. Inputs are pc, end, cnt and pend-hit; output is the match bit.

Test Plan:
1. Reset, then write set0 start=0x100, end=0x120, cnt=3; pc=0x120, accept every cycle -> jumps at cnt 3 and 2; cnt reaches 1; third visit gives hwlp_jump_o=0.
2. Set0 and set1 both with end=0x200, cnt=5, start0=0x180, start1=0x140; pc=0x200 -> targ=0x180; only set0 decrements to 4; set1 stays 5.
3. cnt=2, pc held at end, accept -> jump; next cycle (DEC_PEND on the same set) jump=0; after commit cnt=1.
4. Jump accepted with kill_i=1 in the DEC_PEND cycle -> cnt unchanged (e.g. 7 stays 7); FSM back in IDLE.
5. DEC_PEND on set0 while writing cnt0=10 in the same cycle -> cnt0=10, not 9.
6. With RISCV_HWLP_STATS_EN defined: 4 accepted jumps on set1, then read rsel=3 with raddr=1 -> 0x00000004; a counter write to set1 clears it to 0.
